// File: rtl/pm_switch_seq_pkg.sv
// rtl/pm_switch_seq_pkg.sv - shared types, defaults and output decode for the power-switch sequencer
package pm_switch_seq_pkg;

    localparam int TIMER_W         = 8;
    localparam int DEF_SETTLE_CYC  = 16;
    localparam int DEF_TIMEOUT_CYC = 255;

    typedef enum logic [3:0] {
        ST_ON,
        ST_ISO,
        ST_SAVE,
        ST_SW_OFF,
        ST_OFF,
        ST_SW_ON,
        ST_RESTORE,
        ST_DEISO,
        ST_ERR
    } pm_state_t;

    typedef struct packed {
        logic sw_en;
        logic iso;
        logic ret;
        logic rst_dom;
        logic pwr_on;
        logic busy;
        logic err;
    } pm_out_t;

    // Reset output set differs from the OFF row: retention is not yet engaged.
    localparam pm_out_t RESET_OUT = pm_out_t'(7'b0101000);

    function automatic pm_out_t decode_outputs(input pm_state_t s);
        pm_out_t o;
        o = RESET_OUT;
        case (s)
            ST_ON:      o = pm_out_t'(7'b1000100);
            ST_ISO:     o = pm_out_t'(7'b1100010);
            ST_SAVE:    o = pm_out_t'(7'b1110010);
            ST_SW_OFF:  o = pm_out_t'(7'b0110010);
            ST_OFF:     o = pm_out_t'(7'b0111000);
            ST_SW_ON:   o = pm_out_t'(7'b1111010);
            ST_RESTORE: o = pm_out_t'(7'b1100010);
            ST_DEISO:   o = pm_out_t'(7'b1100010);
            ST_ERR:     o = pm_out_t'(7'b0111001);
            default:    o = RESET_OUT;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pm_switch_seq_timer.sv
// rtl/pm_switch_seq_timer.sv - shared down-counter: load, saturating count down, expire flag
module pm_seq_timer
    import pm_switch_seq_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    output logic               o_expired
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/pm_switch_seq.sv
// rtl/pm_switch_seq.sv - power-domain switch sequencer: isolation, retention, switch chain and domain reset
module pm_switch_seq
    import pm_switch_seq_pkg::*;
#(
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pwr_req_i,
    input  logic sw_ack_i,
    input  logic err_clr_i,
    output logic sw_en_o,
    output logic iso_o,
    output logic ret_o,
    output logic rst_dom_o,
    output logic pwr_on_o,
    output logic busy_o,
    output logic err_o
);

    // Timer holds N-1 on entry so a state with expiry exit lasts exactly N cycles.
    localparam logic [TIMER_W-1:0] SETTLE_LOAD  = TIMER_W'(SETTLE_CYC - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYC - 1);

    pm_state_t          r_state;
    pm_state_t          w_state_next;
    pm_out_t            r_out;
    logic               w_expired;
    logic               w_load;
    logic [TIMER_W-1:0] w_load_val;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_OFF;
            r_out   <= RESET_OUT;
        end else begin
            r_state <= w_state_next;
            r_out   <= decode_outputs(w_state_next);
        end
    end

    // Acknowledge is tested before expiry so a late ack on the final cycle still wins.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ON:      if (!pwr_req_i) w_state_next = ST_ISO;
            ST_ISO:     w_state_next = ST_SAVE;
            ST_SAVE:    if (w_expired) w_state_next = ST_SW_OFF;
            ST_SW_OFF: begin
                if (!sw_ack_i)      w_state_next = ST_OFF;
                else if (w_expired) w_state_next = ST_ERR;
            end
            ST_OFF:     if (pwr_req_i) w_state_next = ST_SW_ON;
            ST_SW_ON: begin
                if (sw_ack_i)       w_state_next = ST_RESTORE;
                else if (w_expired) w_state_next = ST_ERR;
            end
            ST_RESTORE: if (w_expired) w_state_next = ST_DEISO;
            ST_DEISO:   w_state_next = ST_ON;
            ST_ERR:     if (err_clr_i) w_state_next = ST_OFF;
            default:    w_state_next = ST_OFF;
        endcase
    end

    always_comb begin
        w_load     = (w_state_next != r_state);
        w_load_val = '0;
        case (w_state_next)
            ST_SAVE, ST_RESTORE: w_load_val = SETTLE_LOAD;
            ST_SW_OFF, ST_SW_ON: w_load_val = TIMEOUT_LOAD;
            default:             w_load_val = '0;
        endcase
    end

    pm_seq_timer u_timer (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expired  (w_expired)
    );

    assign sw_en_o   = r_out.sw_en;
    assign iso_o     = r_out.iso;
    assign ret_o     = r_out.ret;
    assign rst_dom_o = r_out.rst_dom;
    assign pwr_on_o  = r_out.pwr_on;
    assign busy_o    = r_out.busy;
    assign err_o     = r_out.err;

endmodule

// File: tb/tb_pm_switch_seq.sv
// tb/tb_pm_switch_seq.sv - scoreboard bench: expected output segments (vector, duration) vs monitored DUT outputs
module tb_pm_switch_seq;

    localparam logic [6:0] V_R0   = 7'b0101000;
    localparam logic [6:0] V_ON   = 7'b1000100;
    localparam logic [6:0] V_ISO  = 7'b1100010;
    localparam logic [6:0] V_SAVE = 7'b1110010;
    localparam logic [6:0] V_SWOF = 7'b0110010;
    localparam logic [6:0] V_OFF  = 7'b0111000;
    localparam logic [6:0] V_SWON = 7'b1111010;
    localparam logic [6:0] V_RD   = 7'b1100010;
    localparam logic [6:0] V_ERR  = 7'b0111001;

    typedef struct {
        logic [6:0] v;
        int         len;
    } seg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwr_req = 1'b0;
    logic sw_ack = 1'b0;
    logic err_clr = 1'b0;
    logic sw_en, iso, ret, rst_dom, pwr_on, busy, err;
    logic [6:0] w_vec;

    logic       rst_seen = 1'b1;
    logic       done = 1'b0;
    int         ack_mode = 0;
    seg_t       exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic       active = 1'b0;
    logic [6:0] cur = '0;
    int         len = 0;
    int         seg_idx = 0;
    logic       en_prev = 1'b0;
    int         n_since = 0;

    always #5 clk = ~clk;

    pm_switch_seq dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .pwr_req_i (pwr_req),
        .sw_ack_i  (sw_ack),
        .err_clr_i (err_clr),
        .sw_en_o   (sw_en),
        .iso_o     (iso),
        .ret_o     (ret),
        .rst_dom_o (rst_dom),
        .pwr_on_o  (pwr_on),
        .busy_o    (busy),
        .err_o     (err)
    );

    assign w_vec = {sw_en, iso, ret, rst_dom, pwr_on, busy, err};

    always @(posedge clk) rst_seen <= rst;

    // Switch-chain model: mode 0 acks rise 3 / fall 5 cycles after sw_en; 1 never acks; 2 acks on the 255th cycle.
    always @(negedge clk) begin
        if (sw_en != en_prev) n_since = 0;
        else if (n_since < 100000) n_since = n_since + 1;
        en_prev = sw_en;
        case (ack_mode)
            0: begin
                if (sw_en && n_since >= 3) sw_ack = 1'b1;
                else if (!sw_en && n_since >= 5) sw_ack = 1'b0;
            end
            1: sw_ack = 1'b0;
            default: sw_ack = sw_en && (n_since >= 254);
        endcase
    end

    task automatic close_seg();
        seg_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL seg_unexpected%0d: got vec=%b len=%0d, required no segment", seg_idx, cur, len);
        end else begin
            e = exp_q.pop_front();
            if (e.v !== cur || (e.len != 0 && e.len != len)) begin
                n_errors++;
                $display("FAIL seg%0d: got vec=%b len=%0d, required vec=%b len=%0d (0=any)",
                         seg_idx, cur, len, e.v, e.len);
            end
        end
        seg_idx++;
    endtask

    always @(negedge clk) begin
        if (done) begin
            n_checks++;
            if (exp_q.size() != 0) begin
                n_errors++;
                $display("FAIL sb_drain: %0d expected segments left, required 0", exp_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $finish;
        end else if (rst_seen) begin
            if (active) close_seg();
            active = 1'b0;
            n_checks++;
            if (w_vec !== V_R0) begin
                n_errors++;
                $display("FAIL reset_out: got %b, required %b", w_vec, V_R0);
            end
        end else if (!active) begin
            active = 1'b1;
            cur = w_vec;
            len = 1;
        end else if (w_vec === cur) begin
            len++;
        end else begin
            close_seg();
            cur = w_vec;
            len = 1;
        end
    end

    task automatic push(input logic [6:0] v, input int n);
        seg_t s;
        s.v = v;
        s.len = n;
        exp_q.push_back(s);
    endtask

    task automatic wait_vec(input logic [6:0] v, input int budget, input string name);
        int k = 0;
        while (w_vec !== v && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (w_vec !== v) begin
            $display("FAIL wait_%s: outputs=%b required=%b after %0d cycles", name, w_vec, v, k);
            $fatal(1, "bounded wait expired");
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with power requested, then full power-up.
        pwr_req = 1'b1;
        repeat (3) @(negedge clk);
        push(V_SWON, 4); push(V_RD, 17); push(V_ON, 0);
        rst = 1'b0;
        wait_vec(V_ON, 100, "pwrup");

        // Power-down, ack drops 5 cycles after sw_en falls.
        push(V_ISO, 1); push(V_SAVE, 16); push(V_SWOF, 6); push(V_OFF, 0);
        pwr_req = 1'b0;
        wait_vec(V_OFF, 100, "pwrdn");
        repeat (2) @(negedge clk);

        // No acknowledge: timeout into ERR, then clear back to OFF.
        ack_mode = 1;
        push(V_SWON, 255); push(V_ERR, 0); push(V_OFF, 0);
        pwr_req = 1'b1;
        wait_vec(V_SWON, 10, "swon_to");
        pwr_req = 1'b0;
        wait_vec(V_ERR, 600, "err");
        repeat (3) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        repeat (2) @(negedge clk);

        // Acknowledge on the exact expiry cycle.
        ack_mode = 2;
        push(V_SWON, 255); push(V_RD, 17); push(V_ON, 0);
        pwr_req = 1'b1;
        wait_vec(V_ON, 600, "late_ack");
        repeat (2) @(negedge clk);

        // Request toggled during SAVE: finish to OFF, then power up again.
        ack_mode = 0;
        push(V_ISO, 1); push(V_SAVE, 16); push(V_SWOF, 6); push(V_OFF, 1);
        push(V_SWON, 4); push(V_RD, 17); push(V_ON, 0);
        pwr_req = 1'b0;
        wait_vec(V_SAVE, 10, "save");
        pwr_req = 1'b1;
        @(negedge clk);
        pwr_req = 1'b0;
        @(negedge clk);
        pwr_req = 1'b1;
        wait_vec(V_ON, 200, "repwr");
        repeat (2) @(negedge clk);

        // Reset asserted four cycles into RESTORE.
        push(V_ISO, 1); push(V_SAVE, 16); push(V_SWOF, 6); push(V_OFF, 0);
        push(V_SWON, 4); push(V_RD, 4);
        pwr_req = 1'b0;
        wait_vec(V_OFF, 100, "pwrdn2");
        pwr_req = 1'b1;
        wait_vec(V_RD, 50, "restore");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        pwr_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        done = 1'b1;
    end

endmodule
